// File: rtl/vec_ram_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ram_pipe_pkg
//  Description : Shared constants for the vec_ram_pipe block. Holds the
//                default build-time widths (BE_DATA_W, BE_ADDR_W, BE_STRB_W),
//                the default storage size and read latency, and the helper
//                that derives the response capacity (in-flight + buffered).
//  Macros      : VEC_RAM_BIG_ENDIAN_EN (consumed by vec_ram_pipe)
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_ram_pipe_pkg;

    localparam int BE_DATA_W      = 64;
    localparam int BE_ADDR_W      = 24;
    localparam int BE_STRB_W      = BE_DATA_W / 8;
    localparam int BE_DEPTH_BYTES = 32768;
    localparam int BE_RD_LAT      = 1;

    // One slot per pipeline stage plus one so a stalled consumer never
    // costs a bubble when it releases.
    function automatic int rsp_capacity(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_ram_skid.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ram_skid
//  Description : Small circular FIFO that buffers responses (data + error)
//                while the consumer stalls. Head entry is shown on data_o.
//  Ports       : clk_i, rst_n_i  - clock, async active-low reset
//                push_i, data_i  - enqueue one entry
//                pop_i           - dequeue head entry
//                data_o          - head entry (undefined content when empty)
//                empty_o         - no entries held
//                count_o         - number of entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_ram_skid
    import vec_ram_pipe_pkg::*;
#(
    parameter int W     = BE_DATA_W + 1,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    assign wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= data_i;
                wr_ptr_q         <= wr_ptr_d;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_d;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = slot_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/vec_ram_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ram_pipe
//  Description : Byte-addressed RAM with a valid/ready request port and a
//                valid/ready response port. Every accepted request (read or
//                write) returns one response carrying the pre-write contents,
//                RD_LAT cycles later when the consumer is ready. Unaligned
//                accesses wrap modulo DEPTH_BYTES; addresses at or beyond
//                DEPTH_BYTES return err=1, data=0 and never write.
//  Ports       : clk_i, rst_n_i             - clock, async active-low reset
//                req_valid_i/req_ready_o    - request handshake
//                req_we_i                   - byte strobes (0 = read)
//                req_addr_i, req_d_i        - byte address, write data
//                rsp_valid_o/rsp_ready_i    - response handshake
//                rsp_d_o, rsp_err_o         - read data, out-of-range flag
//  Macros      : VEC_RAM_BIG_ENDIAN_EN - lane i maps to addr+(DATA_W/8-1-i)
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_ram_pipe
    import vec_ram_pipe_pkg::*;
#(
    parameter int DATA_W      = BE_DATA_W,
    parameter int ADDR_W      = BE_ADDR_W,
    parameter int DEPTH_BYTES = BE_DEPTH_BYTES,
    parameter int RD_LAT      = BE_RD_LAT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_W/8-1:0]   req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_d_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_d_o,
    output logic                  rsp_err_o
);

    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = $clog2(DEPTH_BYTES);
    localparam int CAP    = rsp_capacity(RD_LAT);
    localparam int OCC_W  = $clog2(CAP + 1);

    logic [7:0]        mem_q [DEPTH_BYTES];
    logic              init_q;
    logic              s1_vld_q;
    logic              s1_err_q;
    logic [DATA_W-1:0] s1_d_q;

    logic              w_accept;
    logic              w_oor;
    logic [MEM_AW-1:0] w_base;
    logic [MEM_AW-1:0] w_lane_addr [NB];
    logic [DATA_W-1:0] w_rd_data;
    logic              w_out_vld;
    logic              w_out_err;
    logic [DATA_W-1:0] w_out_d;
    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occ;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [OCC_W-1:0]  w_fifo_cnt;
    logic [DATA_W:0]   w_fifo_q;

    assign w_accept = req_valid_i & req_ready_o;
    // DEPTH_BYTES is a power of two, so any bit above the index is out of range.
    assign w_oor    = |(req_addr_i >> MEM_AW);
    assign w_base   = req_addr_i[MEM_AW-1:0];

    // Lane addresses truncate to MEM_AW bits, which gives the modulo wrap.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NB; i++) begin
`ifdef VEC_RAM_BIG_ENDIAN_EN
            w_lane_addr[i] = w_base + MEM_AW'(NB - 1 - i);
`else
            w_lane_addr[i] = w_base + MEM_AW'(i);
`endif
            w_rd_data[i*8 +: 8] = w_oor ? 8'h00 : mem_q[w_lane_addr[i]];
        end
    end

    // Storage is never reset. The read above samples the old contents on the
    // same edge as this write, giving read-before-write per response.
    always_ff @(posedge clk_i) begin
        if (w_accept && !w_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (req_we_i[i]) begin
                    mem_q[w_lane_addr[i]] <= req_d_i[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            init_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_d_q   <= '0;
        end else begin
            init_q   <= 1'b1;
            s1_vld_q <= w_accept;
            if (w_accept) begin
                s1_err_q <= w_oor;
                s1_d_q   <= w_rd_data;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_vld_q;
            logic              s2_err_q;
            logic [DATA_W-1:0] s2_d_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    s2_vld_q <= 1'b0;
                    s2_err_q <= 1'b0;
                    s2_d_q   <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    s2_err_q <= s1_err_q;
                    s2_d_q   <= s1_d_q;
                end
            end

            assign w_out_vld  = s2_vld_q;
            assign w_out_err  = s2_err_q;
            assign w_out_d    = s2_d_q;
            assign w_inflight = OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
        end else begin : g_lat1
            assign w_out_vld  = s1_vld_q;
            assign w_out_err  = s1_err_q;
            assign w_out_d    = s1_d_q;
            assign w_inflight = OCC_W'(s1_vld_q);
        end
    endgenerate

    // Fall-through: with an empty buffer the pipeline output is presented
    // directly and only enters the buffer if the consumer stalls; once the
    // buffer holds anything, new results queue behind it to keep order.
    assign w_push = w_out_vld & ~(w_fifo_empty & rsp_ready_i);
    assign w_pop  = ~w_fifo_empty & rsp_ready_i;

    vec_ram_skid #(
        .W     (DATA_W + 1),
        .DEPTH (CAP)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_push),
        .data_i  ({w_out_err, w_out_d}),
        .pop_i   (w_pop),
        .data_o  (w_fifo_q),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_cnt)
    );

    assign rsp_valid_o = w_out_vld | ~w_fifo_empty;
    assign rsp_d_o     = w_fifo_empty ? w_out_d   : w_fifo_q[DATA_W-1:0];
    assign rsp_err_o   = w_fifo_empty ? w_out_err : w_fifo_q[DATA_W];

    // A consume on the same cycle frees a slot, so a full pipe still accepts.
    assign w_occ       = w_inflight + w_fifo_cnt;
    assign req_ready_o = init_q & ((w_occ < OCC_W'(CAP)) | (rsp_valid_o & rsp_ready_i));

endmodule
`default_nettype wire

// File: tb/tb_vec_ram_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_ram_pipe
//  Description : Self-checking bench for vec_ram_pipe. A byte-array memory
//                model and an expected-response queue predict every response.
//  Macros      : VEC_RAM_BIG_ENDIAN_EN (selects lane mapping of the model)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_ram_pipe;

    localparam int DW    = 64;
    localparam int AW    = 24;
    localparam int DEPTH = 32768;
    localparam int LAT   = 1;
    localparam int NB    = DW / 8;
    localparam int CAP   = LAT + 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [NB-1:0] req_we    = '0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_d     = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_d;

    vec_ram_pipe #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH_BYTES (DEPTH),
        .RD_LAT      (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_d_i     (req_d),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_d_o     (rsp_d),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          err;
        int            acc;
    } exp_t;

    exp_t          q[$];
    logic [7:0]    mm [DEPTH];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    bit            strict = 1'b1;
    logic [DW-1:0] last_d;
    logic          last_err;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int lane_byte(input int unsigned a, input int i);
`ifdef VEC_RAM_BIG_ENDIAN_EN
        return int'((a + int'(NB - 1 - i)) % DEPTH);
`else
        return int'((a + i) % DEPTH);
`endif
    endfunction

    task automatic model_accept();
        exp_t e;
        e.err = (req_addr >= AW'(DEPTH));
        e.d   = '0;
        e.acc = cyc;
        if (!e.err) begin
            for (int i = 0; i < NB; i++) e.d[i*8 +: 8] = mm[lane_byte(req_addr, i)];
            for (int i = 0; i < NB; i++)
                if (req_we[i]) mm[lane_byte(req_addr, i)] = req_d[i*8 +: 8];
        end
        q.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                last_d   = rsp_d;
                last_err = rsp_err;
                chk("rsp_has_request", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_d", rsp_d, e.d);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (strict) chk("rsp_latency", 64'(cyc - e.acc), 64'(LAT));
                    else        chk("rsp_latency_min", 64'(cyc - e.acc >= LAT), 64'd1);
                end
            end
            if (req_valid && req_ready) model_accept();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        score();
        tick();
    endtask

    task automatic send(input logic [NB-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_d     = d;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = req_ready;
            score();
            tick();
        end
        req_valid = 1'b0;
        chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 60 && q.size() != 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        logic [47:0]   got6;
        logic [47:0]   want6;
        int            n_acc;
        bit            acc_prev;
        int            sel;

        // ---------------- reset behaviour ----------------
        rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_d", rsp_d, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        tick();
        chk("rst_req_ready_clocked", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", 64'(req_ready), 64'd0);
        tick();
        chk("ready_after_first_edge", 64'(req_ready), 64'd1);

        // ---------------- initialise the exercised windows ----------------
        for (int a = 0; a <= 104; a += 8) send('1, AW'(a), {$urandom, $urandom});
        send('1, AW'(DEPTH - 16), {$urandom, $urandom});
        send('1, AW'(DEPTH - 8), {$urandom, $urandom});
        wait_empty();

        // ---------------- full write then read ----------------
        send(8'hFF, 24'h10, 64'h0807060504030201);
        send(8'h00, 24'h10, 64'd0);
        wait_empty();
        chk("full_write_readback", last_d, 64'h0807060504030201);
        chk("full_write_err", 64'(last_err), 64'd0);

        // ---------------- partial strobe ----------------
        send(8'h0F, 24'h10, 64'hAAAAAAAABBBBBBBB);
        send(8'h00, 24'h10, 64'd0);
        wait_empty();
        chk("partial_strobe_readback", last_d, 64'h08070605BBBBBBBB);

        // ---------------- wrap at the top of storage ----------------
        pat = 64'h1122334455667788;
        send(8'hFF, AW'(DEPTH - 2), pat);
        send(8'h00, 24'h0, 64'd0);
        wait_empty();
`ifdef VEC_RAM_BIG_ENDIAN_EN
        got6  = last_d[63:16];
        want6 = pat[47:0];
`else
        got6  = last_d[47:0];
        want6 = pat[63:16];
`endif
        chk("wrap_lanes", 64'(got6), 64'(want6));

        // ---------------- out of range ----------------
        send(8'h00, AW'(DEPTH), 64'd0);
        wait_empty();
        chk("oor_read_err", 64'(last_err), 64'd1);
        chk("oor_read_d", last_d, 64'd0);
        send(8'hFF, AW'(DEPTH), '1);
        send(8'h00, 24'h0, 64'd0);
        wait_empty();

        // ---------------- consumer stall, back-to-back requests ----------------
        strict    = 1'b0;
        rsp_ready = 1'b0;
        n_acc     = 0;
        req_valid = 1'b1;
        req_we    = '0;
        req_addr  = AW'($urandom_range(0, 95));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready", 64'(req_ready), 64'(n_acc < CAP));
            score();
            if (req_ready) begin
                n_acc++;
                tick();
                req_addr = AW'($urandom_range(0, 95));
            end else begin
                tick();
            end
        end
        chk("stall_accepts", 64'(n_acc), 64'(CAP));
        chk("stall_rsp_held", 64'(rsp_valid), 64'd1);
        // Full pipe: consuming this cycle must let the pending request in.
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_consume_ready", 64'(req_ready), 64'd1);
        score();
        tick();
        req_valid = 1'b0;
        wait_empty();

        // ---------------- reset with two requests in flight ----------------
        rsp_ready = 1'b0;
        send(8'h00, 24'h8, 64'd0);
        send(8'h00, 24'h18, 64'd0);
        chk("inflight_before_reset", 64'(q.size()), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_drops_req_ready", 64'(req_ready), 64'd0);
        chk("reset_clears_rsp_d", rsp_d, 64'd0);
        q.delete();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
            score();
            tick();
        end
        strict = 1'b1;
        send(8'h00, 24'h10, 64'd0);
        wait_empty();
        chk("storage_kept_over_reset", last_d, 64'h08070605BBBBBBBB);

        // ---------------- randomized traffic ----------------
        strict   = 1'b0;
        acc_prev = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!req_valid || acc_prev) begin
                req_valid = ($urandom % 4) != 0;
                sel       = int'($urandom % 3);
                if (sel == 0)      req_addr = AW'($urandom_range(0, 95));
                else if (sel == 1) req_addr = AW'(DEPTH - 16 + int'($urandom_range(0, 15)));
                else               req_addr = AW'(DEPTH + int'($urandom_range(0, 7)));
                req_we = ($urandom % 2) != 0 ? '0 : NB'($urandom);
                req_d  = {$urandom, $urandom};
            end
            rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc_prev = req_valid && req_ready;
            score();
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
